// File: rtl/color_seq_pkg.sv
// Shared types for the colour sequencer: sequencing modes and hue phases.
package color_seq_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP = 2'd0,
        MODE_HUE  = 2'd1,
        MODE_GRAY = 2'd2,
        MODE_HOLD = 2'd3
    } mode_e;

    // One phase per colour-wheel edge; exactly one channel moves in each.
    typedef enum logic [2:0] {
        PH_0 = 3'd0,
        PH_1 = 3'd1,
        PH_2 = 3'd2,
        PH_3 = 3'd3,
        PH_4 = 3'd4,
        PH_5 = 3'd5
    } hue_phase_e;

    // Phase that follows once the moving channel reaches its limit.
    function automatic hue_phase_e next_phase(input hue_phase_e ph);
        hue_phase_e nxt;
        case (ph)
            PH_0:    nxt = PH_1;
            PH_1:    nxt = PH_2;
            PH_2:    nxt = PH_3;
            PH_3:    nxt = PH_4;
            PH_4:    nxt = PH_5;
            default: nxt = PH_0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/color_sequencer_tick_divider.sv
// Programmable prescaler: strobes tick once every div+1 enabled cycles.
// tick is an unregistered strobe meant to be consumed by registered logic
// in the same clock domain.  Lowering div below the running count lets
// the counter run to its natural wrap before it matches again.
module tick_divider #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             match;

    // Next count and step strobe; clear wins over counting.
    always_comb begin
        cnt_d = cnt_q;
        match = (cnt_q == div);
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (match) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/color_sequencer.sv
// Colour generator for the widget RGB inputs: ramp, hue wheel, gray and
// hold modes, stepped by a programmable prescaler, with registered outputs.
//
// mode state | meaning
// -----------+----------------------------------------------------------
// MODE_RAMP  | {red,green,blue} counts as one 3*CW-bit word
// MODE_HUE   | walks the six edges of the colour wheel, one channel/step
// MODE_GRAY  | all channels equal, level counts 0..MAX
// MODE_HOLD  | colour frozen, prescaler keeps running
//
// hue phase  | meaning
// -----------+----------------------------------------------------------
// PH_0       | green rises to MAX   (red held at MAX)
// PH_1       | red falls to 0       (green held at MAX)
// PH_2       | blue rises to MAX    (green held at MAX)
// PH_3       | green falls to 0     (blue held at MAX)
// PH_4       | red rises to MAX     (blue held at MAX)
// PH_5       | blue falls to 0      (red held at MAX), then wraps to PH_0
module color_sequencer
    import color_seq_pkg::*;
#(
    parameter int CW    = 4,
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] step_div,
    output logic [CW-1:0]    red,
    output logic [CW-1:0]    green,
    output logic [CW-1:0]    blue,
    output logic             tick,
    output logic             wrap
);

    localparam logic [CW-1:0]     MAX     = '1;
    localparam logic [CW-1:0]     ONE     = CW'(1);
    localparam logic [3*CW-1:0]   RGB_ONE = (3*CW)'(1);

    mode_e        mode_in;
    mode_e        mode_q, mode_d;
    hue_phase_e   phase_q, phase_d;
    logic [CW-1:0] red_q, red_d;
    logic [CW-1:0] green_q, green_d;
    logic [CW-1:0] blue_q, blue_d;
    logic         tick_q, tick_d;
    logic         wrap_q, wrap_d;
    logic         mode_chg;
    logic         step;
    logic [3*CW-1:0] rgb_inc;

    assign mode_in  = mode_e'(mode);
    assign mode_chg = (mode_in != mode_q);
    assign rgb_inc  = {red_q, green_q, blue_q} + RGB_ONE;

    // A mode change restarts the prescaler so the new sequence begins
    // on a full step period.
    tick_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (mode_chg),
        .div    (step_div),
        .tick   (step)
    );

    // Next colour, phase, mode and pulses: mode change has priority over a step.
    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (mode_chg) begin
            mode_d = mode_in;
            case (mode_in)
                MODE_RAMP, MODE_GRAY: begin
                    red_d   = '0;
                    green_d = '0;
                    blue_d  = '0;
                end
                MODE_HUE: begin
                    red_d   = MAX;
                    green_d = '0;
                    blue_d  = '0;
                    phase_d = PH_0;
                end
                default: ;
            endcase
        end else if (step) begin
            case (mode_q)
                MODE_RAMP: begin
                    {red_d, green_d, blue_d} = rgb_inc;
                    tick_d = 1'b1;
                    wrap_d = &{red_q, green_q, blue_q};
                end
                MODE_HUE: begin
                    tick_d = 1'b1;
                    case (phase_q)
                        PH_0: begin
                            green_d = green_q + ONE;
                            if (green_q == MAX - ONE) phase_d = next_phase(phase_q);
                        end
                        PH_1: begin
                            red_d = red_q - ONE;
                            if (red_q == ONE) phase_d = next_phase(phase_q);
                        end
                        PH_2: begin
                            blue_d = blue_q + ONE;
                            if (blue_q == MAX - ONE) phase_d = next_phase(phase_q);
                        end
                        PH_3: begin
                            green_d = green_q - ONE;
                            if (green_q == ONE) phase_d = next_phase(phase_q);
                        end
                        PH_4: begin
                            red_d = red_q + ONE;
                            if (red_q == MAX - ONE) phase_d = next_phase(phase_q);
                        end
                        PH_5: begin
                            blue_d = blue_q - ONE;
                            if (blue_q == ONE) begin
                                phase_d = next_phase(phase_q);
                                wrap_d  = 1'b1;
                            end
                        end
                        default: begin
                            // Unreachable encodings recover to the wheel start.
                            phase_d = PH_0;
                            red_d   = MAX;
                            green_d = '0;
                            blue_d  = '0;
                        end
                    endcase
                end
                MODE_GRAY: begin
                    tick_d = 1'b1;
                    if (red_q == MAX) begin
                        red_d   = '0;
                        green_d = '0;
                        blue_d  = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        red_d   = red_q + ONE;
                        green_d = red_q + ONE;
                        blue_d  = red_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= MODE_RAMP;
            phase_q <= PH_0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            phase_q <= phase_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Bench for color_sequencer: directed scenarios plus randomized segments,
// every cycle compared against a sequence-index reference model.
module tb_color_sequencer;

    localparam int CW    = 4;
    localparam int DIV_W = 20;
    localparam int MAXV  = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [1:0]       mode;
    logic [DIV_W-1:0] step_div;
    logic [CW-1:0]    red, green, blue;
    logic             tick, wrap;

    always #5 clk = ~clk;

    color_sequencer #(.CW(CW), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .step_div (step_div),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .tick     (tick),
        .wrap     (wrap)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position in the current mode's sequence.
    int m_mode, m_cnt, m_idx, m_rgb;
    bit m_tick, m_wrap;

    function automatic int seq_len(input int md);
        case (md)
            0:       return 4096;
            1:       return 6 * MAXV;
            default: return MAXV + 1;
        endcase
    endfunction

    function automatic int pack_rgb(input int r, input int g, input int b);
        return r * 256 + g * 16 + b;
    endfunction

    function automatic int hue_rgb(input int idx);
        int p, k;
        p = idx / MAXV;
        k = idx % MAXV;
        case (p)
            0:       return pack_rgb(MAXV, k, 0);
            1:       return pack_rgb(MAXV - k, MAXV, 0);
            2:       return pack_rgb(0, MAXV, k);
            3:       return pack_rgb(0, MAXV - k, MAXV);
            4:       return pack_rgb(k, 0, MAXV);
            default: return pack_rgb(MAXV, 0, MAXV - k);
        endcase
    endfunction

    function automatic int idx_rgb(input int md, input int idx);
        case (md)
            0:       return idx;
            1:       return hue_rgb(idx);
            default: return pack_rgb(idx, idx, idx);
        endcase
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_idx = 0; m_rgb = 0; m_tick = 0; m_wrap = 0;
        end else if (int'(mode) != m_mode) begin
            m_mode = int'(mode); m_cnt = 0; m_tick = 0; m_wrap = 0;
            if (m_mode != 3) begin
                m_idx = 0;
                m_rgb = idx_rgb(m_mode, 0);
            end
        end else begin
            m_tick = 0; m_wrap = 0;
            if (enable) begin
                if (m_cnt == int'(step_div)) begin
                    m_cnt = 0;
                    if (m_mode != 3) begin
                        m_idx  = (m_idx + 1) % seq_len(m_mode);
                        m_rgb  = idx_rgb(m_mode, m_idx);
                        m_tick = 1;
                        m_wrap = (m_idx == 0);
                    end
                end else begin
                    m_cnt = (m_cnt + 1) % (1 << DIV_W);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: update model at the edge, compare just after it.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("rgb",  16'({red, green, blue}), 16'(m_rgb));
        chk("tick", 16'(tick), 16'(m_tick));
        chk("wrap", 16'(wrap), 16'(m_wrap));
    endtask

    int cnt_a, cnt_b;
    logic [11:0] held;

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 2'd0; step_div = '0;
        m_mode = 0; m_cnt = 0; m_idx = 0; m_rgb = 0; m_tick = 0; m_wrap = 0;
        cyc(); cyc();
        chk("rst_rgb", 16'({red, green, blue}), 16'h000);

        // Full ramp: every code once, single wrap.
        reset = 1'b0; enable = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 4096; i++) begin
            cyc();
            if (wrap) cnt_a++;
        end
        chk("ramp_wraps", 16'(cnt_a), 16'd1);
        chk("ramp_end", 16'({red, green, blue}), 16'h000);

        // Gray with step_div=3.
        step_div = 20'd3; mode = 2'd2;
        cyc();
        cnt_a = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (tick) cnt_a++;
        end
        chk("gray_ticks", 16'(cnt_a), 16'd15);
        chk("gray_full", 16'({red, green, blue}), 16'hFFF);
        for (int i = 0; i < 4; i++) cyc();
        chk("gray_zero", 16'({red, green, blue}), 16'h000);
        chk("gray_wrap", 16'(wrap), 16'd1);

        // Hue wheel at full rate.
        step_div = '0; mode = 2'd1;
        cyc();
        chk("hue_start", 16'({red, green, blue}), 16'hF00);
        for (int i = 0; i < 15; i++) cyc();
        chk("hue_15", 16'({red, green, blue}), 16'hFF0);
        for (int i = 0; i < 15; i++) cyc();
        chk("hue_30", 16'({red, green, blue}), 16'h0F0);
        cnt_a = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (wrap) cnt_a++;
        end
        chk("hue_90", 16'({red, green, blue}), 16'hF00);
        chk("hue_wraps", 16'(cnt_a), 16'd1);
        chk("hue_wrap_last", 16'(wrap), 16'd1);

        // Disable mid-hue with step_div=5 and count at 2.
        step_div = 20'd5;
        cyc(); cyc();
        held = {red, green, blue};
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("frozen", 16'({red, green, blue}), 16'(held));
        end
        enable = 1'b1;
        cnt_b = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (tick && cnt_b == 0) cnt_b = i;
        end
        chk("resume_lat", 16'(cnt_b), 16'(5 - 2 + 1));

        // Ramp to 0x123, then hold, then hue.
        reset = 1'b1; mode = 2'd0; step_div = '0;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 12'h123; i++) cyc();
        chk("ramp_123", 16'({red, green, blue}), 16'h123);
        mode = 2'd3;
        cyc();
        cnt_a = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (tick) cnt_a++;
        end
        chk("hold_rgb", 16'({red, green, blue}), 16'h123);
        chk("hold_ticks", 16'(cnt_a), 16'd0);
        mode = 2'd1;
        cyc();
        chk("hold_to_hue", 16'({red, green, blue}), 16'hF00);

        // Reset together with a mode change and a pending step.
        for (int i = 0; i < 7; i++) cyc();
        reset = 1'b1; mode = 2'd2;
        cyc();
        chk("rst_prio_rgb", 16'({red, green, blue}), 16'h000);
        chk("rst_prio_tick", 16'(tick), 16'd0);
        chk("rst_prio_wrap", 16'(wrap), 16'd0);
        reset = 1'b0; mode = 2'd0;
        cyc();
        chk("rst_mode_ramp", 16'({red, green, blue}), 16'h001);

        // Randomized segments; step_div changes only alongside reset.
        for (int s = 0; s < 40; s++) begin
            reset    = 1'b1;
            mode     = 2'($urandom_range(0, 3));
            step_div = DIV_W'($urandom_range(0, 3));
            enable   = 1'b1;
            cyc();
            reset = 1'b0;
            for (int i = 0; i < 80; i++) begin
                enable = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
